conv3x3_seq: RTL and testbench

CONV3X3_SEQ -- requirements
Module: conv3x3_seq

---
 rtl/conv3x3_seq_if.sv | 26 ++
 rtl/conv3x3_seq.sv | 173 +++++++++++++++++
 tb/tb_conv3x3_seq.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv3x3_seq_if.sv
// Handshake and FIFO bus for the 3x3 window sequencer.
// master = sequencer side, slave = producer/FIFO/consumer environment.
interface conv3x3_seq_if #(
  parameter int WORD_WIDTH = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic [3*WORD_WIDTH-1:0] in_data;
  logic                    fifo_write_en;
  logic                    fifo_read_en;
  logic [3*WORD_WIDTH-1:0] fifo_wdata;
  logic [3*WORD_WIDTH-1:0] fifo_rdata;
  logic                    win_valid;
  logic                    win_ready;
  logic [9*WORD_WIDTH-1:0] win_data;

  modport master (
    input  in_valid, in_data, fifo_rdata, win_ready,
    output in_ready, fifo_write_en, fifo_read_en, fifo_wdata, win_valid, win_data
  );

  modport slave (
    output in_valid, in_data, fifo_rdata, win_ready,
    input  in_ready, fifo_write_en, fifo_read_en, fifo_wdata, win_valid, win_data
  );
endinterface

// File: rtl/conv3x3_seq.sv
// 3x3 window sequencer: arbitrates producer writes and window-feeding reads on an external FIFO.
// Defining CONV3X3_SEQ_STALL_CNT_EN adds the stall_cnt output (consumer back-pressure cycles).
//
// state | meaning
// IDLE  | waiting for start; no FIFO traffic
// RUN   | arbitrating writes/reads, building and emitting windows
// DONE  | last window of the frame accepted; frame_done pulses, IDLE next
module conv3x3_seq #(
  parameter int WORD_WIDTH    = 16,
  parameter int DEPTH_TRIPLES = 85,
  parameter int IMG_WIDTH     = 32,
  parameter int IMG_BANDS     = 30,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  conv3x3_seq_if.master        bus,
  output logic [CNT_WIDTH-1:0] occupancy,
  output logic                 busy,
  output logic                 band_done,
  output logic                 frame_done
`ifdef CONV3X3_SEQ_STALL_CNT_EN
  ,
  output logic [15:0]          stall_cnt
`endif
);

  localparam int TW = 3 * WORD_WIDTH;
  localparam int WW = 9 * WORD_WIDTH;
  localparam logic [CNT_WIDTH-1:0] DEPTH_C     = CNT_WIDTH'(DEPTH_TRIPLES);
  localparam logic [CNT_WIDTH-1:0] IMG_W_C     = CNT_WIDTH'(IMG_WIDTH);
  localparam logic [CNT_WIDTH-1:0] LAST_BAND_C = CNT_WIDTH'(IMG_BANDS - 1);
  localparam logic [CNT_WIDTH-1:0] THREE_C     = CNT_WIDTH'(3);
  localparam logic [CNT_WIDTH-1:0] ONE_C       = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CNT_WIDTH-1:0] col_cnt;
  logic [CNT_WIDTH-1:0] band_cnt;
  logic [CNT_WIDTH-1:0] col_inc;
  logic                 rd_inflight;
  logic                 last_grant_rd;
  logic                 win_valid_q;
  logic                 win_last;
  logic [WW-1:0]        win_data_q;

  logic run;
  logic clr;
  logic accept;
  logic rd_elig;
  logic wr_elig;
  logic rd_grant;
  logic wr_grant;
  logic shift_qual;
  logic last_frame_win;

  assign run            = (state == S_RUN);
  assign clr            = (state == S_IDLE) && start;
  assign accept         = win_valid_q && bus.win_ready;
  assign col_inc        = col_cnt + ONE_C;
  assign shift_qual     = rd_inflight && (col_inc >= THREE_C);
  assign band_done      = run && accept && win_last;
  assign last_frame_win = band_done && (band_cnt == LAST_BAND_C);

  // A read may only launch if the window register will be free when its data lands.
  always_comb begin
    rd_elig  = 1'b0;
    wr_elig  = 1'b0;
    rd_grant = 1'b0;
    wr_grant = 1'b0;
    if (run) begin
      rd_elig = (occupancy != '0) && !rd_inflight && (!win_valid_q || bus.win_ready);
      wr_elig = bus.in_valid && (occupancy < DEPTH_C);
    end
    rd_grant = rd_elig && (!wr_elig || !last_grant_rd);
    wr_grant = wr_elig && !rd_grant;
  end

  assign bus.in_ready      = wr_grant;
  assign bus.fifo_write_en = bus.in_valid & wr_grant;
  assign bus.fifo_read_en  = rd_grant;
  assign bus.fifo_wdata    = bus.in_data;
  assign bus.win_valid     = win_valid_q;
  assign bus.win_data      = win_data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (last_frame_win) state_nxt = S_DONE;
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occupancy     <= '0;
      rd_inflight   <= 1'b0;
      last_grant_rd <= 1'b0;
    end else begin
      rd_inflight <= rd_grant;
      if (wr_grant)      occupancy <= occupancy + ONE_C;
      else if (rd_grant) occupancy <= occupancy - ONE_C;
      if (clr)           last_grant_rd <= 1'b0;
      else if (rd_grant) last_grant_rd <= 1'b1;
      else if (wr_grant) last_grant_rd <= 1'b0;
    end
  end

  // New column enters at the top; the oldest column sits in the low bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_cnt     <= '0;
      band_cnt    <= '0;
      win_valid_q <= 1'b0;
      win_last    <= 1'b0;
      win_data_q  <= '0;
    end else if (clr) begin
      col_cnt     <= '0;
      band_cnt    <= '0;
      win_valid_q <= 1'b0;
      win_last    <= 1'b0;
      win_data_q  <= '0;
    end else begin
      if (rd_inflight) begin
        win_data_q <= {bus.fifo_rdata, win_data_q[WW-1:TW]};
        col_cnt    <= (col_inc == IMG_W_C) ? '0 : col_inc;
      end
      if (shift_qual) begin
        win_valid_q <= 1'b1;
        win_last    <= (col_inc == IMG_W_C);
      end else if (accept) begin
        win_valid_q <= 1'b0;
      end
      if (band_done) begin
        band_cnt <= (band_cnt == LAST_BAND_C) ? '0 : band_cnt + ONE_C;
      end
    end
  end

`ifdef CONV3X3_SEQ_STALL_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                                    stall_cnt <= '0;
    else if (clr)                                                  stall_cnt <= '0;
    else if (win_valid_q && !bus.win_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_conv3x3_seq.sv
// Scoreboard bench for conv3x3_seq: behavioural FIFO, directed column streams, monitor-side window checks.
`timescale 1ns/1ps
module tb_conv3x3_seq;
  localparam int WW    = 16;
  localparam int IW    = 4;
  localparam int IB    = 2;
  localparam int DEPTH = 85;
  localparam int CW    = 8;
  localparam int TW    = 3 * WW;
  localparam int NW    = 9 * WW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  conv3x3_seq_if #(.WORD_WIDTH(WW)) bus ();
  logic [CW-1:0] occupancy;
  logic          busy, band_done, frame_done;
`ifdef CONV3X3_SEQ_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  conv3x3_seq #(
    .WORD_WIDTH(WW), .DEPTH_TRIPLES(DEPTH), .IMG_WIDTH(IW), .IMG_BANDS(IB), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(rst_n), .start(start), .bus(bus),
    .occupancy(occupancy), .busy(busy), .band_done(band_done), .frame_done(frame_done)
`ifdef CONV3X3_SEQ_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  int n_vec = 0;
  int n_miss = 0;

  // External FIFO: read data appears the cycle after fifo_read_en.
  logic [TW-1:0] fifo_q[$];
  int fifo_underflow = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q.delete();
      bus.fifo_rdata <= '0;
    end else begin
      if (bus.fifo_write_en) fifo_q.push_back(bus.fifo_wdata);
      if (bus.fifo_read_en) begin
        if (fifo_q.size() > 0) bus.fifo_rdata <= fifo_q.pop_front();
        else fifo_underflow++;
      end
    end
  end

  logic [NW-1:0] exp_q[$];
  int band_seen = 0, frame_seen = 0, both_en_seen = 0, occ_max = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.win_valid && bus.win_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_miss++;
          $display("FAIL window_unexpected: got %h, no window expected", bus.win_data);
        end else begin
          logic [NW-1:0] e;
          e = exp_q.pop_front();
          if (bus.win_data !== e) begin
            n_miss++;
            $display("FAIL window: got %h, expected %h", bus.win_data, e);
          end
        end
      end
      if (band_done) band_seen++;
      if (frame_done) frame_seen++;
      if (bus.fifo_write_en && bus.fifo_read_en) both_en_seen++;
      if (int'(occupancy) > occ_max) occ_max = int'(occupancy);
    end
  end

  logic [TW-1:0] stim[$];
  logic [TW-1:0] hist[$];
  int n_acc, sent, cyc = 0, rd_seen, first_valid_cyc, third_rd_cyc;
  bit prod_en = 0;
  int grants[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic load_stim(input int base, input int n);
    stim.delete();
    for (int c = 0; c < n; c++) begin
      logic [WW-1:0] w0, w1, w2;
      w0 = WW'(base + 3 * c);
      w1 = WW'(base + 3 * c + 1);
      w2 = WW'(base + 3 * c + 2);
      stim.push_back({w2, w1, w0});
    end
  endtask

  // Expected window = three most recent columns of the band, newest in the high bits.
  task automatic accept_col(input logic [TW-1:0] d);
    hist.push_back(d);
    if ((n_acc % IW) >= 2) exp_q.push_back({hist[$], hist[$-1], hist[$-2]});
    n_acc++;
    sent++;
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (bus.in_valid && bus.in_ready) accept_col(bus.in_data);
    if (bus.fifo_read_en) begin
      grants.push_back(1);
      rd_seen++;
      if (rd_seen == 3 && third_rd_cyc < 0) third_rd_cyc = cyc;
    end
    if (bus.fifo_write_en) grants.push_back(2);
    if (bus.win_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    @(posedge clk);
    #1;
    if (prod_en && sent < stim.size()) begin
      bus.in_valid = 1'b1;
      bus.in_data  = stim[sent];
    end else begin
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic frame_start();
    hist.delete();
    grants.delete();
    n_acc = 0;
    sent = 0;
    rd_seen = 0;
    first_valid_cyc = -1;
    third_rd_cyc = -1;
    prod_en = 1;
    bus.in_valid = 1'b1;
    bus.in_data  = stim[0];
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_until_frame(input string name, input int budget);
    int f0, k;
    f0 = frame_seen;
    k = 0;
    while (frame_seen == f0 && k < budget) begin
      step();
      k++;
    end
    check({name, "_frame_timeout"}, longint'(frame_seen != f0), 1);
    repeat (2) step();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_occupancy"}, occupancy, 0);
    check({tag, "_in_ready"}, bus.in_ready, 0);
    check({tag, "_fifo_write_en"}, bus.fifo_write_en, 0);
    check({tag, "_fifo_read_en"}, bus.fifo_read_en, 0);
    check({tag, "_win_valid"}, bus.win_valid, 0);
    check({tag, "_win_data_zero"}, longint'(bus.win_data == '0), 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_band_done"}, band_done, 0);
    check({tag, "_frame_done"}, frame_done, 0);
`ifdef CONV3X3_SEQ_STALL_CNT_EN
    check({tag, "_stall_cnt"}, stall_cnt, 0);
`endif
  endtask

  // Continuous producer, always-ready consumer: grants W,R,W,R,... and two bands per frame.
  task automatic frame_checks(input string name, input int b0, input int f0);
    int pat[6];
    pat = '{2, 1, 2, 1, 2, 1};
    for (int i = 0; i < 6; i++)
      check($sformatf("%s_grant%0d", name, i), (i < grants.size()) ? grants[i] : -1, pat[i]);
    check({name, "_read_to_valid"}, first_valid_cyc - third_rd_cyc, 2);
    check({name, "_band_done_cnt"}, band_seen - b0, IB);
    check({name, "_frame_done_cnt"}, frame_seen - f0, 1);
    check({name, "_end_occupancy"}, occupancy, 0);
    check({name, "_end_busy"}, busy, 0);
    check({name, "_windows_left"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int b0, f0, k, changes, rd0, rdy_hi, g0;
    logic [NW-1:0] snap;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.win_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst_init");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Frame A: 8 columns, consumer always ready.
    load_stim(16'h0100, IW * IB);
    bus.win_ready = 1'b1;
    b0 = band_seen;
    f0 = frame_seen;
    frame_start();
    run_until_frame("frameA", 200);
    frame_checks("frameA", b0, f0);

    // Frame B: consumer stalls, producer fills the FIFO.
    load_stim(16'h2000, 100);
    bus.win_ready = 1'b0;
    frame_start();
    k = 0;
    while (first_valid_cyc < 0 && k < 50) begin
      step();
      k++;
    end
    check("stall_valid_timeout", longint'(first_valid_cyc >= 0), 1);
    snap = bus.win_data;
    rd0 = rd_seen;
    changes = 0;
    repeat (9) begin
      step();
      if (bus.win_data !== snap) changes++;
    end
    check("stall_win_data_changes", changes, 0);
    check("stall_reads", rd_seen - rd0, 0);
    check("stall_win_valid", bus.win_valid, 1);
`ifdef CONV3X3_SEQ_STALL_CNT_EN
    check("stall_cnt", stall_cnt, 10);
`endif
    k = 0;
    while (int'(occupancy) != DEPTH && k < 300) begin
      step();
      k++;
    end
    check("fill_occupancy", occupancy, DEPTH);
    rdy_hi = 0;
    repeat (5) begin
      step();
      if (bus.in_ready) rdy_hi++;
    end
    check("full_in_ready_high", rdy_hi, 0);
    check("full_occupancy_held", occupancy, DEPTH);
    check("full_occ_max", occ_max, DEPTH);

    g0 = grants.size();
    bus.win_ready = 1'b1;
    repeat (6) step();
    for (int i = 0; i < 4; i++)
      check($sformatf("alt_grant%0d", i), (g0 + i < grants.size()) ? grants[g0 + i] : -1,
            (i % 2 == 0) ? 1 : 2);

    // Reset mid-frame with data in the FIFO.
    check("pre_reset_busy", busy, 1);
    check("pre_reset_occ_nonzero", longint'(occupancy != '0), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("rst_run");
    exp_q.delete();
    hist.delete();
    prod_en = 0;
    bus.in_valid  = 1'b0;
    bus.win_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Frame D: clean frame after reset.
    load_stim(16'h5000, IW * IB);
    bus.win_ready = 1'b1;
    b0 = band_seen;
    f0 = frame_seen;
    frame_start();
    run_until_frame("frameD", 200);
    frame_checks("frameD", b0, f0);

    check("both_enables_cycles", both_en_seen, 0);
    check("fifo_underflow", fifo_underflow, 0);
    check("occ_max_bound", longint'(occ_max <= DEPTH), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
